// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default baud divisor and
// parity-sense constants. Also intended for the receive side.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_START   = 3'd1,
    TX_DATA    = 3'd2,
    TX_PARITY  = 3'd3,
    TX_STOP    = 3'd4,
    TX_CLEANUP = 3'd5
  } tx_state_t;

  localparam int CLKS_PER_BIT_115200 = 868;

  localparam bit PARITY_SENSE_EVEN = 1'b0;
  localparam bit PARITY_SENSE_ODD  = 1'b1;

  function automatic logic parity_of(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit period. Wraps to 0 on every bit boundary.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign bit_tick = enable && !clear && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_byte.sv
// Byte-wide UART transmitter (8 data bits, LSB first, optional parity, 1 or 2
// stop bits) with registered line and status outputs.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      tx_start,
  input  logic [7:0] tx_byte,
  output logic      tx_serial,
  output logic      tx_active,
  output logic      tx_done,
  output tx_state_t tx_state
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_byte: CLKS_PER_BIT must be >= 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx_byte: STOP_BITS must be 1 or 2");
  end

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic ODD_SENSE = 1'(PARITY_ODD);

  tx_state_t  state_q;
  logic [7:0] shreg_q;
  logic [2:0] bit_idx_q;
  logic       stop_cnt_q;
  logic       tx_serial_q, tx_active_q, tx_done_q;
  logic       timer_clear, bit_tick;

  assign timer_clear = (state_q == TX_IDLE) || (state_q == TX_CLEANUP);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (!timer_clear),
    .bit_tick(bit_tick)
  );

  // Handshake: tx_start is a level request sampled only in IDLE; the requester
  // holds it until it sees the one-cycle tx_done pulse. CLEANUP ignores
  // tx_start, so a request dropped on the tx_done edge yields exactly one frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= TX_IDLE;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      stop_cnt_q  <= 1'b0;
      tx_serial_q <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          tx_serial_q <= 1'b1;
          tx_active_q <= 1'b0;
          tx_done_q   <= 1'b0;
          if (tx_start) begin
            shreg_q     <= tx_byte;
            state_q     <= TX_START;
            tx_serial_q <= 1'b0;
            tx_active_q <= 1'b1;
          end
        end
        TX_START: begin
          if (bit_tick) begin
            state_q     <= TX_DATA;
            bit_idx_q   <= 3'd0;
            tx_serial_q <= shreg_q[0];
          end
        end
        TX_DATA: begin
          if (bit_tick) begin
            if (bit_idx_q == 3'd7) begin
              if (PARITY_EN != 0) begin
                state_q     <= TX_PARITY;
                tx_serial_q <= parity_of(shreg_q, ODD_SENSE);
              end else begin
                state_q     <= TX_STOP;
                stop_cnt_q  <= 1'b0;
                tx_serial_q <= 1'b1;
              end
            end else begin
              bit_idx_q   <= bit_idx_q + 3'd1;
              tx_serial_q <= shreg_q[bit_idx_q + 3'd1];
            end
          end
        end
        TX_PARITY: begin
          if (bit_tick) begin
            state_q     <= TX_STOP;
            stop_cnt_q  <= 1'b0;
            tx_serial_q <= 1'b1;
          end
        end
        TX_STOP: begin
          if (bit_tick) begin
            if (stop_cnt_q == STOP_LAST) begin
              state_q     <= TX_CLEANUP;
              tx_active_q <= 1'b0;
              tx_done_q   <= 1'b1;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end
        TX_CLEANUP: begin
          state_q     <= TX_IDLE;
          tx_serial_q <= 1'b1;
          tx_active_q <= 1'b0;
          tx_done_q   <= 1'b0;
        end
        default: begin
          state_q     <= TX_IDLE;
          tx_serial_q <= 1'b1;
          tx_active_q <= 1'b0;
          tx_done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_serial = tx_serial_q;
  assign tx_active = tx_active_q;
  assign tx_done   = tx_done_q;
  assign tx_state  = state_q;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Directed bench for uart_tx_byte: four instances (8N1, even parity, odd parity,
// two stop bits) at CLKS_PER_BIT = 4, with a frame-decoding scoreboard on 8N1.
module tb_uart_tx_byte;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic clk, reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] exp_q[$];
  int   a_frames = 0;
  int   a_dones  = 0;

  logic a_start, p_start, o_start, s_start;
  logic [7:0] a_byte, p_byte, o_byte, s_byte;
  logic a_serial, p_serial, o_serial, s_serial;
  logic a_active, p_active, o_active, s_active;
  logic a_done, p_done, o_done, s_done;
  tx_state_t a_state, p_state, o_state, s_state;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  uart_tx_byte #(.CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .reset(reset), .tx_start(a_start), .tx_byte(a_byte),
    .tx_serial(a_serial), .tx_active(a_active), .tx_done(a_done), .tx_state(a_state));
  uart_tx_byte #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .reset(reset), .tx_start(p_start), .tx_byte(p_byte),
    .tx_serial(p_serial), .tx_active(p_active), .tx_done(p_done), .tx_state(p_state));
  uart_tx_byte #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut_o (
    .clk(clk), .reset(reset), .tx_start(o_start), .tx_byte(o_byte),
    .tx_serial(o_serial), .tx_active(o_active), .tx_done(o_done), .tx_state(o_state));
  uart_tx_byte #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_s (
    .clk(clk), .reset(reset), .tx_start(s_start), .tx_byte(s_byte),
    .tx_serial(s_serial), .tx_active(s_active), .tx_done(s_done), .tx_state(s_state));

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_a_done(input string tag);
    int w;
    w = 0;
    while (a_done !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk(tag, a_done, 1'b1);
  endtask

  always @(negedge clk) if (a_done === 1'b1) a_dones++;

  // Scoreboard: decodes each 8N1 frame mid-bit, pops the expected byte.
  initial begin : mon_a
    logic [9:0] fb;
    bit aborted;
    fb = '0;
    forever begin
      @(negedge clk);
      if (a_active === 1'b1) begin
        aborted = 1'b0;
        for (int c = 0; c < 10 * CPB; c++) begin
          if (c > 0) @(negedge clk);
          if (a_active !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (c % CPB == CPB / 2) fb[c / CPB] = a_serial;
        end
        if (aborted) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          a_frames++;
          chk("mon_start_bit", fb[0], 1'b0);
          chk("mon_stop_bit", fb[9], 1'b1);
          chk("mon_frame_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) chk("mon_byte", fb[8:1], exp_q.pop_front());
          @(negedge clk);
          chk("mon_done_after_frame", a_done, 1'b1);
          chk("mon_inactive_in_cleanup", a_active, 1'b0);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [9:0]  f1;
    logic [10:0] fp, fo;
    int f0, d0;
    reset = 1'b1;
    a_start = 0; p_start = 0; o_start = 0; s_start = 0;
    a_byte = 0;  p_byte = 0;  o_byte = 0;  s_byte = 0;
    repeat (3) @(negedge clk);
    chk("rst_a_serial", a_serial, 1'b1);
    chk("rst_a_active", a_active, 1'b0);
    chk("rst_a_done", a_done, 1'b0);
    chk("rst_a_state", a_state, TX_IDLE);
    chk("rst_p_serial", p_serial, 1'b1);
    chk("rst_s_active", s_active, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Test 1: single pulse 0xA5, exact line waveform and tx_done timing
    f1 = {1'b1, 8'hA5, 1'b0};
    a_byte = 8'hA5; a_start = 1'b1; exp_q.push_back(8'hA5);
    @(negedge clk);
    a_start = 1'b0;
    for (int c = 0; c < 10 * CPB; c++) begin
      chk("t1_serial", a_serial, f1[c / CPB]);
      chk("t1_active", a_active, 1'b1);
      chk("t1_done_low", a_done, 1'b0);
      @(negedge clk);
    end
    chk("t1_done_pulse", a_done, 1'b1);
    chk("t1_active_off", a_active, 1'b0);
    @(negedge clk);
    chk("t1_done_one_cycle", a_done, 1'b0);

    // Test 2: requester holds tx_start until it sees tx_done
    f0 = a_frames; d0 = a_dones;
    for (int b = 1; b <= 4; b++) begin
      a_byte = 8'(b); a_start = 1'b1; exp_q.push_back(8'(b));
      wait_a_done("t2_done_seen");
      @(posedge clk);
      #1 a_start = 1'b0;
      @(negedge clk);
      chk("t2_idle_after_frame", a_active, 1'b0);
    end
    repeat (60) @(negedge clk);
    chk("t2_frames", a_frames - f0, 4);
    chk("t2_done_pulses", a_dones - d0, 4);
    chk("t2_queue_empty", exp_q.size(), 0);

    // Test 3: tx_start/tx_byte changed mid-frame, then back-to-back restart
    f0 = a_frames; d0 = a_dones;
    a_byte = 8'h3C; a_start = 1'b1; exp_q.push_back(8'h3C);
    @(negedge clk);
    a_start = 1'b0;
    repeat (13) @(negedge clk);
    a_byte = 8'hFF; a_start = 1'b1; exp_q.push_back(8'hFF);
    chk("t3_serial_bit2", a_serial, 1'b1);
    wait_a_done("t3_done_first");
    @(negedge clk);
    chk("t3_idle_between", a_active, 1'b0);
    @(negedge clk);
    chk("t3_b2b_restart", a_active, 1'b1);
    a_start = 1'b0;
    wait_a_done("t3_done_second");
    repeat (60) @(negedge clk);
    chk("t3_frames", a_frames - f0, 2);
    chk("t3_done_pulses", a_dones - d0, 2);

    // Test 4: reset during DATA bit 3, then a clean 0x55
    f0 = a_frames; d0 = a_dones;
    a_byte = 8'h96; a_start = 1'b1; exp_q.push_back(8'h96);
    @(negedge clk);
    a_start = 1'b0;
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t4_serial_after_reset", a_serial, 1'b1);
    chk("t4_active_after_reset", a_active, 1'b0);
    chk("t4_done_after_reset", a_done, 1'b0);
    chk("t4_state_after_reset", a_state, TX_IDLE);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("t4_no_done_pulse", a_dones - d0, 0);
    chk("t4_aborted_popped", exp_q.size(), 0);
    a_byte = 8'h55; a_start = 1'b1; exp_q.push_back(8'h55);
    @(negedge clk);
    a_start = 1'b0;
    wait_a_done("t4_done_0x55");
    repeat (5) @(negedge clk);
    chk("t4_frames", a_frames - f0, 1);
    chk("t4_queue_empty", exp_q.size(), 0);

    // Test 5: even and odd parity on 0x07, 44-cycle frame
    fp = {1'b1, 1'b1, 8'h07, 1'b0};
    fo = {1'b1, 1'b0, 8'h07, 1'b0};
    p_byte = 8'h07; o_byte = 8'h07; p_start = 1'b1; o_start = 1'b1;
    @(negedge clk);
    p_start = 1'b0; o_start = 1'b0;
    for (int c = 0; c < 11 * CPB; c++) begin
      chk("t5_even_serial", p_serial, fp[c / CPB]);
      chk("t5_odd_serial", o_serial, fo[c / CPB]);
      chk("t5_even_active", p_active, 1'b1);
      chk("t5_odd_active", o_active, 1'b1);
      @(negedge clk);
    end
    chk("t5_even_done", p_done, 1'b1);
    chk("t5_odd_done", o_done, 1'b1);
    chk("t5_even_active_off", p_active, 1'b0);

    // Test 6: two stop bits on 0x00
    @(negedge clk);
    s_byte = 8'h00; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int c = 0; c < 11 * CPB; c++) begin
      chk("t6_serial", s_serial, (c >= 9 * CPB) ? 1'b1 : 1'b0);
      chk("t6_active", s_active, 1'b1);
      chk("t6_done_low", s_done, 1'b0);
      @(negedge clk);
    end
    chk("t6_done_pulse", s_done, 1'b1);
    chk("t6_active_off", s_active, 1'b0);
    @(negedge clk);
    chk("t6_done_one_cycle", s_done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_byte.md
Name: uart_tx_byte

Overview:
Byte-wide UART transmitter: the serial-output end of the command/result FSM's TX handshake.
- Accepts one byte per request on tx_start / tx_byte.
- Serialises the byte as 8N1 by default, with optional parity and a second stop bit.
- Reports progress on tx_active / tx_done in the form the command FSM expects.
- Sits between the crypto command FSM (SIMON/SHA result output) and the board TX pin.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); must be >= 2.
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN = 1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tx_start  in  1  request to send; level-sampled only in IDLE; may be held high by the requester.
- tx_byte  in  8  byte to send; captured on the accepting edge.
- tx_serial  out  1  serial line; idles high.
- tx_active  out  1  high while a frame is on the line.
- tx_done  out  1  one-cycle pulse after the last stop bit.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk. All outputs are registered.
- Reset values: tx_serial = 1, tx_active = 0, tx_done = 0, state = IDLE, counters = 0.
- States: IDLE, START, DATA, PARITY, STOP, CLEANUP.
- IDLE:
  - tx_serial = 1, tx_active = 0, tx_done = 0.
  - If tx_start = 1 at an edge: latch tx_byte into a shift register, go to START, clear the bit-clock counter.
- START:
  - tx_serial = 0, tx_active = 1, for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx_serial = shreg[bit index], LSB first, each bit held for CLKS_PER_BIT cycles.
  - After bit 7: go to PARITY if PARITY_EN = 1, otherwise STOP.
- PARITY:
  - tx_serial = ^latched_byte XOR PARITY_ODD, for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx_serial = 1, tx_active = 1, for STOP_BITS * CLKS_PER_BIT cycles, then go to CLEANUP.
- CLEANUP:
  - Lasts exactly 1 cycle: tx_done = 1, tx_active = 0, tx_serial = 1, tx_start ignored.
  - Then go to IDLE.
- Timing:
  - First START cycle appears on tx_serial the cycle after the accepting edge.
  - Frame length = (1 + 8 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
  - tx_done follows in the next cycle.
- Handshake compatibility:
  - The requester raises tx_start while tx_active = 0 and tx_done = 0, holds it, and drops it on the edge where it sees tx_done.
  - The CLEANUP cycle plus IDLE level-sampling must therefore produce exactly one frame per request, with no duplicate send.
- Boundary conditions:
  - tx_start or tx_byte changes mid-frame: no effect; the latched byte is sent unchanged.
  - tx_start still high in the first IDLE cycle after CLEANUP: a new frame starts. Intended for back-to-back use.
  - Reset mid-frame: on the next edge go to IDLE, tx_serial = 1, tx_active = 0; no tx_done pulse.
  - Bit-clock counter is $clog2(CLKS_PER_BIT) bits wide, counts 0..CLKS_PER_BIT-1, and wraps to 0 on each bit boundary.
- Elaboration-time assertions: CLKS_PER_BIT >= 2; STOP_BITS in {1, 2}.

Decomposition:
- Shared package uart_pkg contains:
  - tx_state_t enum.
  - Default baud constant CLKS_PER_BIT_115200 = 868.
  - Parity-sense constants.
- The package is reused by the future uart_rx.
- One sub-module: uart_bit_timer.
  - Inputs: clear, enable. Outputs: bit_tick. Parameter: CLKS_PER_BIT.
  - Shared with the RX side.
- All other logic stays in one FSM.

Test Plan:
1. CLKS_PER_BIT=4, 8N1, pulse tx_start with 0xA5 -> tx_serial = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. tx_active is high for 40 cycles, then tx_done is high for exactly 1 cycle at cycle 41.
2. Command-FSM-style requester, tx_start held until tx_done, bytes 0x01..0x04 -> exactly 4 frames and 4 tx_done pulses. Decoded bytes are 01,02,03,04; no duplicate frame.
3. Start 0x3C, then set tx_start=1 with tx_byte=0xFF during DATA bit 2 -> frame still decodes 0x3C. No second frame until IDLE.
4. Reset asserted in DATA bit 3 -> next cycle tx_serial = 1 and tx_active = 0; tx_done never pulses. A new request of 0x55 afterwards transmits correctly.
5. PARITY_EN=1, byte 0x07 -> parity bit = 1 with PARITY_ODD=0 and 0 with PARITY_ODD=1. Frame length is 44 cycles at CLKS_PER_BIT=4.
6. STOP_BITS=2, byte 0x00 -> line high for 8 cycles after bit 7. tx_done occurs 44 cycles after the first start cycle.
